ps2_key_event_rx: RTL
=====================

Name: ps2_key_event_rx

Overview:
- Next-generation PS/2 keyboard receiver.
- Samples the PS/2 clock and data lines, validates each 11-bit frame (start, 8 data, odd parity, stop), and folds the E0/F0 prefixes into tagged key events.
- Buffers events in a parametrised FIFO with a valid/ready handshake, so game logic (snake direction, start/pause, menu keys) never misses a keystroke.
- Adds a frame timeout and error reporting.

Parameters:
- SYNC_STAGES, 3: synchroniser depth on ps2_clk_in and ps2_data_in; minimum 2.
- TIMEOUT_CYCLES, 50000: clk cycles with no PS/2 falling edge mid-frame before the frame is aborted.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of fifo_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ps2_clk_in  in  1  raw PS/2 clock
- ps2_data_in  in  1  raw PS/2 data
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts the head event
- evt_code  out  8  scancode at the FIFO head
- evt_ext  out  1  head event had an E0 prefix
- evt_break  out  1  head event had an F0 prefix (key release)
- fifo_count  out  CNT_W  current FIFO occupancy
- parity_err  out  1  one-cycle pulse
- frame_err  out  1  one-cycle pulse (bad start, bad stop, or timeout)
- overflow  out  1  one-cycle pulse; event dropped

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, prefix flags cleared, synchroniser stages 1.
- Both inputs pass through SYNC_STAGES flops.
- Falling edge is detected when the previous synchronised clock is 1 and the current one is 0. Data is sampled on that same cycle from the synchronised data line.
- Receive FSM:
  - IDLE: on a falling edge, if data = 0 go to DATA with bit index 0. Otherwise stay in IDLE and pulse frame_err.
  - DATA: shift LSB first on each edge; after bit 7 go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: on the edge, check the frame:
    - data = 0: frame_err.
    - XOR of the 8 data bits and the parity bit is not 1: parity_err.
    - Otherwise the byte is accepted.
    - Always return to IDLE.
- Timeout: a counter is cleared on every falling edge and counts only outside IDLE. On reaching TIMEOUT_CYCLES-1, return to IDLE, pulse frame_err, and clear the prefix flags.
- Accepted byte handling:
  - 8'hE0 sets ext_flag.
  - 8'hF0 sets brk_flag.
  - Any other byte pushes {ext_flag, brk_flag, byte} into the FIFO and clears both flags.
  - Any parity or frame error also clears both flags.
- Latency: a push is visible on evt_valid 1 cycle after the stop-bit edge cycle.
- FIFO:
  - Show-ahead; evt_* hold the head while evt_valid = 1.
  - Pop occurs when evt_valid && evt_ready.
  - Push when full with no pop in the same cycle: event dropped, overflow pulses, contents unchanged.
  - Full with pop and push in the same cycle: both happen, count unchanged, no overflow.
  - Empty with push: evt_valid rises the next cycle. There is no fall-through in the same cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame or with the FIFO non-empty discards everything immediately.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- When defined:
  - A 512-bit key-down map indexed by {ext, code} is maintained.
  - A make for a key already marked down is discarded (auto-repeat suppression) with no overflow pulse.
  - A break clears the bit and is always pushed.
  - Reset clears the map.
- When undefined: every make, including typematic repeats, is pushed, and no map exists.

Decomposition:
- Package ps2_pkg holds:
  - Constants PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_BRK = 8'hF0.
  - The receive-state enum (IDLE, DATA, PARITY, STOP).
  - A 10-bit packed key-event typedef {ext, brk, code[7:0]}.
- Sub-module ps2_event_fifo: parametrised by FIFO_DEPTH and a 10-bit payload; provides push, pop, full, empty, count and the overflow pulse.

Test Plan:
- Send a valid frame 8'h1D (W) -> one event {ext=0, brk=0, code=8'h1D}; no error pulses.
- Send E0, F0, 75 -> exactly one event {ext=1, brk=1, code=8'h75}; prefixes produce no events.
- Send 8'h29 with the parity bit inverted -> parity_err pulses once, no event; a following F0 29 yields {0, 1, 8'h29}.
- Send 5 bits, then hold the PS/2 clock high for TIMEOUT_CYCLES -> frame_err pulses; the next full frame 8'h5A is received correctly.
- evt_ready = 0, send FIFO_DEPTH+1 make codes -> fifo_count = FIFO_DEPTH, overflow pulses once, and the drained order matches the first FIFO_DEPTH codes.
- With PS2_TYPEMATIC_FILTER_EN defined, send 1C 1C 1C F0 1C -> exactly two events: {0, 0, 8'h1C} and {0, 1, 8'h1C}.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-event receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead key-event FIFO; a push into a full FIFO without a pop is dropped and flagged.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  key_evt_t         wdata,
  input  logic             pop,
  output key_evt_t         rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  key_evt_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign rdata    = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push & ~do_push;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frame checking, E0/F0 prefix folding and a buffered event stream.
// Optional PS2_TYPEMATIC_FILTER_EN drops repeated makes of keys already held down.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2_clk_in,
  input  logic             ps2_data_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [CNT_W-1:0] fifo_count,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s, ps2_data_s, fall;

  rx_state_e        state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic             perr_q, perr_d, ferr_q, ferr_d;
  logic             byte_ok, push, fifo_push, fifo_empty;
  key_evt_t         push_evt, head_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    byte_ok   = 1'b0;
    push      = 1'b0;
    push_evt  = '{ext: ext_q, brk: brk_q, code: shift_q};

    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!ps2_data_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = ps2_data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!ps2_data_s) ferr_d = 1'b1;
          else if (^{shift_q, parity_q} != 1'b1) perr_d = 1'b1;
          else byte_ok = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        tmo_d   = '0;
        ferr_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end

    if (ferr_d || perr_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end

    if (byte_ok) begin
      if (shift_q == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] down_q, down_d;
  logic [8:0]   key_idx;

  assign key_idx = {ext_q, shift_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) down_q <= '0;
    else       down_q <= down_d;
  end

  // Map tracks the key state even when the FIFO drops the event.
  always_comb begin
    down_d    = down_q;
    fifo_push = push;
    if (push) begin
      if (brk_q) begin
        down_d[key_idx] = 1'b0;
      end else if (down_q[key_idx]) begin
        fifo_push = 1'b0;
      end else begin
        down_d[key_idx] = 1'b1;
      end
    end
  end
`else
  assign fifo_push = push;
`endif

  ps2_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wdata   (push_evt),
    .pop     (evt_valid & evt_ready),
    .rdata   (head_evt),
    .full    (),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .overflow(overflow)
  );

  assign evt_valid  = ~fifo_empty;
  assign evt_code   = head_evt.code;
  assign evt_ext    = head_evt.ext;
  assign evt_break  = head_evt.brk;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule
